// File: rtl/div_nbit_seq_if.sv
// ---------------------------------------------------------------------------
// div_nbit_seq_if
// Start/busy/done handshake bundle for the sequential divider.
//   master : requester (execute stage) - drives start, dividend, divisor
//            (and is_signed when DIV_SIGNED_EN is defined)
//   slave  : divider - drives busy, done, quotient, remainder, div_zero
// Vectors are [0:WIDTH-1], bit 0 is the MSB.
// ---------------------------------------------------------------------------
interface div_nbit_seq_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic [0:WIDTH-1]   dividend;
    logic [0:WIDTH-1]   divisor;
`ifdef DIV_SIGNED_EN
    logic               is_signed;
`endif
    logic               busy;
    logic               done;
    logic [0:WIDTH-1]   quotient;
    logic [0:WIDTH-1]   remainder;
    logic               div_zero;

    modport master (
        output start, dividend, divisor,
`ifdef DIV_SIGNED_EN
        output is_signed,
`endif
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
`ifdef DIV_SIGNED_EN
        input  is_signed,
`endif
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/div_nbit_seq.sv
// ---------------------------------------------------------------------------
// div_nbit_seq
// Multi-cycle restoring integer divider, one quotient bit per clock, MSB
// first. Serves DIV/REM beside the ALU; the pipeline stalls on busy.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : div_nbit_seq_if.slave (start/dividend/divisor in,
//          busy/done/quotient/remainder/div_zero out)
// Optional macro DIV_SIGNED_EN: adds bus.is_signed; signed operands are
// divided as magnitudes and sign-fixed in FIN (truncating division).
// Timing: start taken at edge N -> busy for WIDTH+1 cycles (CALC+FIN),
// done pulses in the cycle after edge N+WIDTH+1 with the new results.
// ---------------------------------------------------------------------------
module div_nbit_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    div_nbit_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_rem;      // partial remainder
    logic [WIDTH-1:0]   r_dvd;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   r_dsr;      // divisor magnitude
    logic [CW-1:0]      r_cnt;
    logic               r_dz;       // divisor was zero
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_r;
    logic               r_div_zero;

    logic               w_sgn;
    logic [WIDTH-1:0]   w_a, w_b;
    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_lo;
    logic [WIDTH-1:0]   w_trial;
    logic               w_cy;
    logic               w_ge;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_src;
    logic [WIDTH-1:0]   w_r_fix;

`ifdef DIV_SIGNED_EN
    assign w_sgn = bus.is_signed;
`else
    assign w_sgn = 1'b0;
`endif

    assign w_a     = bus.dividend;
    assign w_b     = bus.divisor;
    assign w_a_neg = w_sgn & w_a[WIDTH-1];
    assign w_b_neg = w_sgn & w_b[WIDTH-1];

    // WIDTH+1-bit trial subtract of {rem,dvd_msb} - divisor, done as an add
    // with inverted divisor and carry-in 1. The shifted-out top remainder
    // bit is the (WIDTH+1)th bit: if it is set the trial is always
    // non-negative and the low WIDTH bits of the sum are the exact result.
    assign w_lo              = {r_rem[WIDTH-2:0], r_dvd[WIDTH-1]};
    assign {w_cy, w_trial}   = {1'b0, w_lo} + {1'b0, ~r_dsr} + {{WIDTH{1'b0}}, 1'b1};
    assign w_ge              = r_rem[WIDTH-1] | w_cy;

    // Sign fix-up. MIN_INT / -1 falls out naturally: magnitude 2^(W-1)
    // negated is itself. On divide-by-zero r_dvd still holds the dividend
    // magnitude, so re-applying the dividend sign restores the dividend.
    assign w_q_fix = r_neg_q ? -r_dvd : r_dvd;
    assign w_r_src = r_dz ? r_dvd : r_rem;
    assign w_r_fix = r_neg_r ? -w_r_src : w_r_src;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rem      <= '0;
            r_dvd      <= '0;
            r_dsr      <= '0;
            r_cnt      <= '0;
            r_dz       <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_q        <= '0;
            r_r        <= '0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (bus.start && !r_done) begin
                        r_dvd   <= w_a_neg ? -w_a : w_a;
                        r_dsr   <= w_b_neg ? -w_b : w_b;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_dz    <= (w_b == '0);
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_busy  <= 1'b1;
                        r_state <= (w_b == '0) ? FIN : CALC;
                    end
                end
                CALC: begin
                    r_rem <= w_ge ? w_trial : w_lo;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH-1))
                        r_state <= FIN;
                end
                FIN: begin
                    r_q        <= r_dz ? '1 : w_q_fix;
                    r_r        <= w_r_fix;
                    r_div_zero <= r_dz;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.quotient  = r_q;
    assign bus.remainder = r_r;
    assign bus.div_zero  = r_div_zero;
endmodule

// File: tb/tb_div_nbit_seq.sv
// ---------------------------------------------------------------------------
// tb_div_nbit_seq
// Directed and randomized checks of div_nbit_seq against a plain-arithmetic
// reference model (/ and % on integers). Drives and samples on negedge.
// ---------------------------------------------------------------------------
module tb_div_nbit_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    logic sgn;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    div_nbit_seq_if #(.WIDTH(W)) bus();

`ifdef DIV_SIGNED_EN
    assign bus.is_signed = sgn;
`endif

    div_nbit_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: divide-by-zero rule, else integer / and %. Signed uses
    // 64-bit ints so MIN_INT / -1 yields +2^31, which truncates to MIN_INT.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        longint sa, sb;
        dz = 1'b0;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // One division. Returns edges from start to done, busy-cycle count and
    // whether outputs held still while busy. inj_at >= 0 pulses a 9/3 start
    // that many cycles into the operation.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int inj_at,
                      output int lat, output int bcnt, output logic stable);
        logic [W-1:0] q0, r0;
        logic         dz0;
        @(negedge clk);
        q0  = bus.quotient;
        r0  = bus.remainder;
        dz0 = bus.div_zero;
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b; sgn = s;
        @(negedge clk);
        bus.start = 1'b0; bus.dividend = $urandom; bus.divisor = $urandom;
        lat = 0; bcnt = 0; stable = 1'b1;
        while (!bus.done && lat < 100) begin
            if (bus.busy) bcnt++;
            if (bus.quotient !== q0 || bus.remainder !== r0 || bus.div_zero !== dz0) stable = 1'b0;
            if (lat == inj_at) begin
                bus.start = 1'b1; bus.dividend = 9; bus.divisor = 3;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        if (lat >= 100) chk("timeout", 1, 0);
    endtask

    task automatic check_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int lat, bcnt;
        logic stable;
        logic [W-1:0] eq, er;
        logic edz;
        model(a, b, s, eq, er, edz);
        op(a, b, s, -1, lat, bcnt, stable);
        chk({tag, "_q"}, bus.quotient, eq);
        chk({tag, "_r"}, bus.remainder, er);
        chk({tag, "_dz"}, bus.div_zero, edz);
        if (b != '0) chk({tag, "_lat"}, lat, W + 1);
        else         chk({tag, "_lat0"}, (lat >= 1 && lat <= 2), 1);
    endtask

    initial begin
        int lat, bcnt, seen;
        logic stable;
        logic [W-1:0] a, b;
        logic s;

        rst = 1'b1; sgn = 1'b0;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_q", bus.quotient, 0);
        chk("rst_r", bus.remainder, 0);
        chk("rst_dz", bus.div_zero, 0);
        @(negedge clk); rst = 1'b0;

        // 100 / 7 with full timing checks
        op(100, 7, 0, -1, lat, bcnt, stable);
        chk("t1_lat", lat, 33);
        chk("t1_busy", bcnt, 33);
        chk("t1_stable", stable, 1);
        chk("t1_q", bus.quotient, 14);
        chk("t1_r", bus.remainder, 2);
        chk("t1_dz", bus.div_zero, 0);
        @(negedge clk);
        chk("t1_done_pulse", bus.done, 0);

        check_op("max_by1", 32'hFFFF_FFFF, 1, 0);
        check_op("lt_div", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);
        check_op("dz", 5, 0, 0);
        check_op("dz_clear", 10, 3, 0);

        // start while busy ignored; start on done cycle ignored
        op(100, 7, 0, 9, lat, bcnt, stable);
        chk("busy_ign_lat", lat, 33);
        chk("busy_ign_q", bus.quotient, 14);
        chk("busy_ign_r", bus.remainder, 2);
        bus.start = 1'b1; bus.dividend = 9; bus.divisor = 3;
        @(negedge clk);
        bus.start = 1'b0;
        chk("done_ign_busy", bus.busy, 0);
        chk("done_ign_q", bus.quotient, 14);
        check_op("after_done", 9, 3, 0);

        // reset mid-operation
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 1000; bus.divisor = 10; sgn = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_q", bus.quotient, 0);
        chk("mid_rst_r", bus.remainder, 0);
        chk("mid_rst_dz", bus.div_zero, 0);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        chk("mid_rst_quiet", seen, 0);
        check_op("post_rst", 1000, 10, 0);

`ifdef DIV_SIGNED_EN
        check_op("s_m7_2", -32'sd7, 2, 1);
        check_op("s_7_m2", 7, -32'sd2, 1);
        check_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1);
        check_op("s_dz", -32'sd5, 0, 1);
`endif

        // randomized: mix of zero, small, full-range divisors and dividends
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 15));
                3:       begin b = $urandom; a = b >> $urandom_range(1, 8); end
                default: b = $urandom >> $urandom_range(0, 28);
            endcase
`ifdef DIV_SIGNED_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            check_op("rnd", a, b, s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
